// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the two-channel FIFO drain arbiter.
package fifo_arb_pkg;

   localparam int NUM_CH    = 2;
   localparam int BUF_DEPTH = 2;

   typedef logic [1:0] state_t;
   localparam state_t IDLE      = 2'd0;
   localparam state_t BURST     = 2'd1;
   localparam state_t WAIT_DONE = 2'd2;

   typedef logic [$clog2(NUM_CH)-1:0] grant_t;

endpackage

// File: rtl/fifo_arb_skid_buf.sv
// Two-entry output buffer holding FIFO words plus their channel/sop/eop tags.
module fifo_arb_skid_buf
   import fifo_arb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             push_chan,
   input  logic             push_sop,
   input  logic             push_eop,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_chan,
   output logic             out_sop,
   output logic             out_eop,
   output logic [1:0]       count
);

   localparam int EW = WIDTH + 3;

   logic [EW-1:0] mem [BUF_DEPTH];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    cnt;
   logic          pop;
   logic [EW-1:0] head;

   assign out_valid = (cnt != 2'd0);
   assign pop       = out_valid && out_ready;
   // Idle outputs read as zero so nothing stale is visible downstream.
   assign head      = out_valid ? mem[rd_ptr] : '0;
   assign {out_data, out_chan, out_sop, out_eop} = head;
   assign count     = cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {push_data, push_chan, push_sop, push_eop};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of two FIFOs into one burst stream; each grant reads exactly
// BURST_LEN words and absorbs the FIFO's one-cycle read latency in a 2-entry buffer.
module fifo_drain_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int LEVEL_WIDTH = 12,
   parameter int BURST_LEN   = 256,
   parameter int CNT_WIDTH   = $clog2(BURST_LEN + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [NUM_CH-1:0]      rd_en,
   input  logic [DATA_WIDTH-1:0]  rd_data0,
   input  logic [DATA_WIDTH-1:0]  rd_data1,
   input  logic [NUM_CH-1:0]      rd_empty,
   input  logic [LEVEL_WIDTH-1:0] rd_water_level0,
   input  logic [LEVEL_WIDTH-1:0] rd_water_level1,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic                   out_chan,
   output logic                   out_sop,
   output logic                   out_eop,
   output logic                   busy,
   output logic                   burst_done
);

   localparam logic [CNT_WIDTH-1:0]   BURST_MAX  = CNT_WIDTH'(BURST_LEN);
   localparam logic [CNT_WIDTH-1:0]   BURST_LAST = CNT_WIDTH'(BURST_LEN - 1);
   localparam logic [LEVEL_WIDTH-1:0] LEVEL_THR  = LEVEL_WIDTH'(BURST_LEN);
   localparam logic [1:0]             BUF_FULL   = 2'(BUF_DEPTH);

   state_t                state;
   grant_t                grant;
   grant_t                last_grant;
   grant_t                pick;
   grant_t                inflight_chan;
   logic [CNT_WIDTH-1:0]  issued;
   logic [CNT_WIDTH-1:0]  fwd_cnt;
   logic                  inflight;
   logic                  inflight_sop;
   logic                  inflight_eop;
   logic [NUM_CH-1:0]     elig;
   logic [1:0]            buf_cnt;
   logic [1:0]            occ;
   logic                  pop;
   logic                  room;
   logic                  issue;
   logic                  last_accept;
   logic [DATA_WIDTH-1:0] cap_data;

   assign elig[0] = (rd_water_level0 >= LEVEL_THR) && !rd_empty[0];
   assign elig[1] = (rd_water_level1 >= LEVEL_THR) && !rd_empty[1];

   // A read is only issued if its word is guaranteed a buffer slot on return.
   assign pop   = out_valid && out_ready;
   assign occ   = buf_cnt + {1'b0, inflight};
   assign room  = (occ < BUF_FULL) || ((occ == BUF_FULL) && pop);
   assign issue = !rst && (state == BURST) && (issued != BURST_MAX)
                  && !rd_empty[grant] && room;

   assign last_accept = (state == WAIT_DONE) && pop && (fwd_cnt == BURST_LAST);
   assign burst_done  = last_accept && !rst;
   assign busy        = (state != IDLE);
   assign cap_data    = (inflight_chan == grant_t'(1)) ? rd_data1 : rd_data0;

   always_comb begin
      rd_en        = '0;
      rd_en[grant] = issue;
   end

   always_comb begin
      if (elig == 2'b11)  pick = ~last_grant;
      else if (elig[0])   pick = grant_t'(0);
      else                pick = grant_t'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         grant         <= grant_t'(0);
         last_grant    <= grant_t'(1);
         issued        <= '0;
         fwd_cnt       <= '0;
         inflight      <= 1'b0;
         inflight_chan <= grant_t'(0);
         inflight_sop  <= 1'b0;
         inflight_eop  <= 1'b0;
      end else begin
         inflight      <= issue;
         inflight_chan <= grant;
         inflight_sop  <= issue && (issued == '0);
         inflight_eop  <= issue && (issued == BURST_LAST);
         if (issue) issued <= issued + CNT_WIDTH'(1);
         if (pop && (fwd_cnt != BURST_MAX)) fwd_cnt <= fwd_cnt + CNT_WIDTH'(1);
         case (state)
            IDLE: begin
               if (|elig) begin
                  state      <= BURST;
                  grant      <= pick;
                  last_grant <= pick;
                  issued     <= '0;
                  fwd_cnt    <= '0;
               end
            end
            BURST:     if (issue && (issued == BURST_LAST)) state <= WAIT_DONE;
            WAIT_DONE: if (last_accept) state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

   fifo_arb_skid_buf #(.WIDTH(DATA_WIDTH)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data (cap_data),
      .push_chan (inflight_chan),
      .push_sop  (inflight_sop),
      .push_eop  (inflight_eop),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_sop   (out_sop),
      .out_eop   (out_eop),
      .count     (buf_cnt)
   );

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed bench for fifo_drain_arbiter: a BURST_LEN=4 instance and a BURST_LEN=1
// instance, each fed by a simple FIFO read model returning incrementing bytes.
module tb_fifo_drain_arbiter;

   typedef struct packed {
      logic       chan;
      logic [7:0] data;
      logic       sop;
      logic       eop;
   } word_t;

   logic        clk;
   logic        rst;

   logic [1:0]  rd_en;
   logic [7:0]  rd_data0 = 8'h00;
   logic [7:0]  rd_data1 = 8'h00;
   logic [1:0]  rd_empty;
   logic [11:0] rd_water_level0;
   logic [11:0] rd_water_level1;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_chan;
   logic        out_sop;
   logic        out_eop;
   logic        busy;
   logic        burst_done;

   logic [1:0]  b_rd_en;
   logic [7:0]  b_rd_data0 = 8'h00;
   logic [7:0]  b_rd_data1 = 8'h00;
   logic [1:0]  b_empty;
   logic [11:0] b_level0;
   logic [11:0] b_level1;
   logic        b_valid;
   logic        b_ready;
   logic [7:0]  b_data;
   logic        b_chan;
   logic        b_sop;
   logic        b_eop;
   logic        b_busy;
   logic        b_done;

   logic [7:0]  src0  = 8'h10;
   logic [7:0]  src1  = 8'h80;
   logic [7:0]  bsrc0 = 8'h40;
   logic [7:0]  bsrc1 = 8'hC0;

   int total = 0;
   int bad   = 0;
   int cycle_no = 0;
   int reads_total, acc_total, max_out, done_cnt, done_b;
   int rd0_cnt, rd0_first, rd0_last, first_valid, hold_err, both_err;
   bit any_busy, any_rd;
   word_t acc_q[$];
   word_t acc_b_q[$];
   logic  prev_valid, prev_ready;
   word_t prev_word;
   logic        s_busy, s_valid, s_chan, s_sop, s_eop, s_done;
   logic [1:0]  s_rd_en;
   logic [7:0]  s_data;
   logic [3:0]  pat = 4'b1001;

   fifo_drain_arbiter #(.DATA_WIDTH(8), .LEVEL_WIDTH(12), .BURST_LEN(4)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .rd_data0(rd_data0), .rd_data1(rd_data1),
      .rd_empty(rd_empty), .rd_water_level0(rd_water_level0),
      .rd_water_level1(rd_water_level1), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_chan(out_chan), .out_sop(out_sop), .out_eop(out_eop),
      .busy(busy), .burst_done(burst_done)
   );

   fifo_drain_arbiter #(.DATA_WIDTH(8), .LEVEL_WIDTH(12), .BURST_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .rd_en(b_rd_en), .rd_data0(b_rd_data0), .rd_data1(b_rd_data1),
      .rd_empty(b_empty), .rd_water_level0(b_level0), .rd_water_level1(b_level1),
      .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data), .out_chan(b_chan),
      .out_sop(b_sop), .out_eop(b_eop), .busy(b_busy), .burst_done(b_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // FIFO read side without output register: data appears the cycle after rd_en.
   always @(posedge clk) begin
      if (rd_en[0])   begin rd_data0   <= src0;  src0  <= src0 + 8'd1;  end
      if (rd_en[1])   begin rd_data1   <= src1;  src1  <= src1 + 8'd1;  end
      if (b_rd_en[0]) begin b_rd_data0 <= bsrc0; bsrc0 <= bsrc0 + 8'd1; end
      if (b_rd_en[1]) begin b_rd_data1 <= bsrc1; bsrc1 <= bsrc1 + 8'd1; end
   end

   function automatic word_t mkw(input logic c, input logic [7:0] d, input logic s, input logic e);
      return '{chan: c, data: d, sop: s, eop: e};
   endfunction

   task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task checkWord(input string tag, input int idx, input word_t exp);
      word_t obs;
      obs = (idx < acc_q.size()) ? acc_q[idx] : word_t'('1);
      checkOutput(tag, 32'(obs), 32'(exp));
   endtask

   task applyStimulus(input logic [11:0] l0, input logic [11:0] l1,
                      input logic [1:0] emp, input logic rdy);
      rd_water_level0 = l0;
      rd_water_level1 = l1;
      rd_empty        = emp;
      out_ready       = rdy;
   endtask

   task clearLogs();
      acc_q.delete();
      reads_total = 0; acc_total = 0; max_out = 0; done_cnt = 0;
      rd0_cnt = 0; rd0_first = -1; rd0_last = -1; first_valid = -1;
      hold_err = 0; both_err = 0; any_busy = 0; any_rd = 0;
      prev_valid = 1'b0; prev_ready = 1'b1; prev_word = '0;
   endtask

   // Sample at the falling edge, then return just after the next rising edge.
   task tick();
      word_t cur;
      @(negedge clk);
      cycle_no++;
      s_busy = busy; s_rd_en = rd_en; s_valid = out_valid; s_data = out_data;
      s_chan = out_chan; s_sop = out_sop; s_eop = out_eop; s_done = burst_done;
      cur = '{chan: out_chan, data: out_data, sop: out_sop, eop: out_eop};
      if (rd_en == 2'b11) both_err++;
      if (busy) any_busy = 1'b1;
      if (|rd_en) any_rd = 1'b1;
      if (rd_en[0]) begin
         if (rd0_cnt == 0) rd0_first = cycle_no;
         rd0_last = cycle_no;
         rd0_cnt++;
      end
      reads_total += int'(rd_en[0]) + int'(rd_en[1]);
      if (prev_valid && !prev_ready && !(out_valid && cur == prev_word)) hold_err++;
      if (out_valid && first_valid < 0) first_valid = cycle_no;
      if (out_valid && out_ready) begin
         acc_q.push_back(cur);
         acc_total++;
      end
      if (reads_total - acc_total > max_out) max_out = reads_total - acc_total;
      if (burst_done) done_cnt++;
      prev_valid = out_valid; prev_ready = out_ready; prev_word = cur;
      if (b_valid && b_ready)
         acc_b_q.push_back('{chan: b_chan, data: b_data, sop: b_sop, eop: b_eop});
      if (b_done) done_b++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(12'd0, 12'd0, 2'b11, 1'b1);
      b_level0 = 12'd0; b_level1 = 12'd0; b_empty = 2'b11; b_ready = 1'b1;
      done_b = 0;
      clearLogs();
      @(posedge clk);
      #1;
      tick();
      rst = 1'b0;
      clearLogs();

      // reset state
      tick();
      checkOutput("reset_state",
                  32'({s_busy, s_rd_en, s_valid, s_chan, s_sop, s_eop, s_done, s_data}), 32'd0);

      // single channel burst, ready always high
      applyStimulus(12'd4, 12'd0, 2'b10, 1'b1);
      clearLogs();
      for (int g = 0; g < 30 && done_cnt < 1; g++) tick();
      applyStimulus(12'd0, 12'd0, 2'b11, 1'b1);
      checkOutput("t1_done", done_cnt, 1);
      checkOutput("t1_rd_cnt", rd0_cnt, 4);
      checkOutput("t1_rd_span", rd0_last - rd0_first, 3);
      checkOutput("t1_latency", first_valid - rd0_first, 2);
      checkOutput("t1_count", acc_q.size(), 4);
      checkWord("t1_w0", 0, mkw(1'b0, 8'h10, 1'b1, 1'b0));
      checkWord("t1_w1", 1, mkw(1'b0, 8'h11, 1'b0, 1'b0));
      checkWord("t1_w2", 2, mkw(1'b0, 8'h12, 1'b0, 1'b0));
      checkWord("t1_w3", 3, mkw(1'b0, 8'h13, 1'b0, 1'b1));

      // both channels eligible: alternate grants starting from channel 0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(12'd4, 12'd4, 2'b00, 1'b1);
      clearLogs();
      for (int g = 0; g < 80 && done_cnt < 4; g++) tick();
      applyStimulus(12'd0, 12'd0, 2'b11, 1'b1);
      checkOutput("t2_done", done_cnt, 4);
      checkOutput("t2_count", acc_q.size(), 16);
      checkOutput("t2_both_rd", both_err, 0);
      checkWord("t2_w0", 0, mkw(1'b0, 8'h14, 1'b1, 1'b0));
      checkWord("t2_w4", 4, mkw(1'b1, 8'h80, 1'b1, 1'b0));
      checkWord("t2_w8", 8, mkw(1'b0, 8'h18, 1'b1, 1'b0));
      checkWord("t2_w12", 12, mkw(1'b1, 8'h84, 1'b1, 1'b0));
      checkWord("t2_w15", 15, mkw(1'b1, 8'h87, 1'b0, 1'b1));

      // backpressure with ready pattern 1,0,0,1
      applyStimulus(12'd4, 12'd0, 2'b10, 1'b1);
      clearLogs();
      for (int k = 0; k < 60 && done_cnt < 1; k++) begin
         out_ready = pat[k % 4];
         tick();
      end
      applyStimulus(12'd0, 12'd0, 2'b11, 1'b1);
      checkOutput("t3_done", done_cnt, 1);
      checkOutput("t3_count", acc_q.size(), 4);
      checkWord("t3_w0", 0, mkw(1'b0, 8'h1C, 1'b1, 1'b0));
      checkWord("t3_w1", 1, mkw(1'b0, 8'h1D, 1'b0, 1'b0));
      checkWord("t3_w2", 2, mkw(1'b0, 8'h1E, 1'b0, 1'b0));
      checkWord("t3_w3", 3, mkw(1'b0, 8'h1F, 1'b0, 1'b1));
      checkOutput("t3_hold", hold_err, 0);
      checkOutput("t3_outstanding_le2", 32'(max_out <= 2), 32'd1);

      // level one below threshold, then exactly at threshold
      applyStimulus(12'd3, 12'd0, 2'b10, 1'b1);
      clearLogs();
      repeat (5) tick();
      checkOutput("t4_busy_low", 32'(any_busy), 32'd0);
      checkOutput("t4_rd_low", 32'(any_rd), 32'd0);
      applyStimulus(12'd4, 12'd0, 2'b10, 1'b1);
      tick();
      checkOutput("t4_pre_grant", 32'(s_busy), 32'd0);
      tick();
      checkOutput("t4_grant", 32'(s_busy), 32'd1);
      for (int g = 0; g < 30 && done_cnt < 1; g++) tick();
      applyStimulus(12'd0, 12'd0, 2'b11, 1'b1);
      checkOutput("t4_done", done_cnt, 1);
      checkWord("t4_w0", 0, mkw(1'b0, 8'h20, 1'b1, 1'b0));

      // reset after two of four words have been accepted
      applyStimulus(12'd4, 12'd0, 2'b10, 1'b1);
      clearLogs();
      for (int g = 0; g < 30 && acc_total < 2; g++) tick();
      checkOutput("t5_pre_accepted", acc_total, 2);
      rst = 1'b1;
      tick();
      checkOutput("t5_rst_rden", 32'(s_rd_en), 32'd0);
      rst = 1'b0;
      applyStimulus(12'd4, 12'd4, 2'b00, 1'b1);
      clearLogs();
      tick();
      checkOutput("t5_after_rst",
                  32'({s_busy, s_rd_en, s_valid, s_chan, s_sop, s_eop, s_done, s_data}), 32'd0);
      for (int g = 0; g < 30 && done_cnt < 1; g++) tick();
      applyStimulus(12'd0, 12'd0, 2'b11, 1'b1);
      checkOutput("t5_done", done_cnt, 1);
      checkOutput("t5_count", acc_q.size(), 4);
      checkWord("t5_w0", 0, mkw(1'b0, 8'h28, 1'b1, 1'b0));
      checkWord("t5_w3", 3, mkw(1'b0, 8'h2B, 1'b0, 1'b1));

      // single-word bursts
      b_level0 = 12'd1;
      b_empty  = 2'b10;
      for (int g = 0; g < 40 && done_b < 2; g++) tick();
      b_level0 = 12'd0;
      b_empty  = 2'b11;
      checkOutput("t6_done", done_b, 2);
      checkOutput("t6_count", acc_b_q.size(), 2);
      checkOutput("t6_w0", 32'((acc_b_q.size() > 0) ? acc_b_q[0] : word_t'('1)),
                  32'(mkw(1'b0, 8'h40, 1'b1, 1'b1)));
      checkOutput("t6_w1", 32'((acc_b_q.size() > 1) ? acc_b_q[1] : word_t'('1)),
                  32'(mkw(1'b0, 8'h41, 1'b1, 1'b1)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
